// File: rtl/qc_ldpc_pkg.sv
// Purpose : shared constants and types for the 27/162 QC-LDPC encoder, loader and decoder.
// Latency : n/a (types only).
// Backpr. : n/a (types only).
//
// K = information bits, M = parity bits, N = codeword length.
// grow_t holds one 162-bit generator parity row per information bit.
package qc_ldpc_pkg;

    localparam int K = 27;
    localparam int M = 162;
    localparam int N = K + M;

    typedef logic [K-1:0] info_t;
    typedef logic [M-1:0] par_t;
    typedef par_t         grow_t [K-1:0];

    // 8 bits is enough for any popcount over 162 bits.
    typedef logic [7:0]   cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYND = 2'd1,
        ST_EVAL = 2'd2
    } dec_state_t;

endpackage

// File: rtl/qc_decoder_if.sv
// Purpose : handshake/data bundle between the channel slicer and the QC-LDPC decoder.
// Latency : n/a (wires only).
// Backpr. : master must hold valid/info_in/par_in until o_ready, and h stable while o_ready is low.
//
// Signals: valid, info_in[26:0], par_in[161:0], h[26:0][161:0] (master -> decoder)
//          o_ready, o_valid, data_out[26:0], o_fail, o_iter[3:0] (decoder -> master)
interface qc_decoder_if;
    import qc_ldpc_pkg::*;

    logic        valid;
    info_t       info_in;
    par_t        par_in;
    grow_t       h;

    logic        o_ready;
    logic        o_valid;
    info_t       data_out;
    logic        o_fail;
    logic [3:0]  o_iter;

    modport master (
        output valid, info_in, par_in, h,
        input  o_ready, o_valid, data_out, o_fail, o_iter
    );

    modport slave (
        input  valid, info_in, par_in, h,
        output o_ready, o_valid, data_out, o_fail, o_iter
    );

endinterface

// File: rtl/qc_popcount162.sv
// Purpose : number of set bits in a 162-bit vector.
// Latency : combinational, zero cycles.
// Backpr. : none (pure function of the input).
//
// Ports: i_vec[161:0] vector to count, o_cnt[7:0] number of ones.
module qc_popcount162
    import qc_ldpc_pkg::*;
(
    input  par_t i_vec,
    output cnt_t o_cnt
);

    always_comb begin
        o_cnt = '0;
        for (int b = 0; b < M; b++) begin
            o_cnt = o_cnt + cnt_t'(i_vec[b]);
        end
    end

endmodule

// File: rtl/qc_decoder.sv
// Purpose : hard-decision bit-flipping decoder for the 27/162 QC-LDPC code.
// Latency : o_valid pulses 2+2k edges after accept (k = flip iterations, k <= MAX_ITER).
// Backpr. : one word in flight; o_ready low from accept until the o_valid cycle, valid ignored meanwhile.
//
// Ports: clk, rst (sync, active-high), bus (qc_decoder_if.slave: valid/info_in/par_in/h in,
//        o_ready/o_valid/data_out/o_fail/o_iter out).
// Compile option: QC_DEC_STALL_DETECT_EN -- when defined, a non-zero syndrome that is too heavy
// to be parity-only yet flips no information bit fails immediately instead of idling to MAX_ITER.
module qc_decoder
    import qc_ldpc_pkg::*;
#(
    parameter int MAX_ITER    = 8,
    parameter int PAR_ERR_TOL = 2
)(
    input  logic         clk,
    input  logic         rst,
    qc_decoder_if.slave  bus
);

    localparam logic [3:0] MAX_IT = 4'(MAX_ITER);
    localparam cnt_t       TOL    = cnt_t'(PAR_ERR_TOL);

    dec_state_t r_state;
    info_t      r_c;
    par_t       r_p;
    par_t       r_s;
    logic [3:0] r_iter;

    logic       r_ready;
    logic       r_valid;
    info_t      r_data;
    logic       r_fail;
    logic [3:0] r_oiter;

    par_t       w_synd;
    cnt_t       w_u [K];
    cnt_t       w_w [K];
    cnt_t       w_swt;
    info_t      w_q;
    logic       w_s_zero;
    logic       w_q_zero;
    logic       w_par_only;

    // Syndrome of the current working word: received parity against re-encoded info bits.
    always_comb begin
        w_synd = r_p;
        for (int i = 0; i < K; i++) begin
            if (r_c[i]) begin
                w_synd = w_synd ^ bus.h[i];
            end
        end
    end

    // Per information bit: flip when more than half of its parity checks are unsatisfied.
    for (genvar gi = 0; gi < K; gi++) begin : g_row
        par_t w_and;
        assign w_and = bus.h[gi] & r_s;

        qc_popcount162 u_pc_u (.i_vec(w_and),       .o_cnt(w_u[gi]));
        qc_popcount162 u_pc_w (.i_vec(bus.h[gi]),   .o_cnt(w_w[gi]));

        // 2u can reach 324, so compare at 9 bits.
        assign w_q[gi] = ({w_u[gi], 1'b0} > {1'b0, w_w[gi]});
    end

    qc_popcount162 u_pc_s (.i_vec(r_s), .o_cnt(w_swt));

    assign w_s_zero   = (r_s == '0);
    assign w_q_zero   = (w_q == '0);
    // Light residue with nothing to flip: the errors sit in the parity bits only.
    assign w_par_only = w_q_zero && (w_swt <= TOL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_c     <= '0;
            r_p     <= '0;
            r_s     <= '0;
            r_iter  <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_fail  <= 1'b0;
            r_oiter <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.valid) begin
                        r_c     <= bus.info_in;
                        r_p     <= bus.par_in;
                        r_iter  <= '0;
                        r_ready <= 1'b0;
                        r_state <= ST_SYND;
                    end
                end
                ST_SYND: begin
                    r_s     <= w_synd;
                    r_state <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (w_s_zero || w_par_only) begin
                        r_valid <= 1'b1;
                        r_data  <= r_c;
                        r_fail  <= 1'b0;
                        r_oiter <= r_iter;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
`ifdef QC_DEC_STALL_DETECT_EN
                    end else if (w_q_zero) begin
                        // Nothing would change on another pass; give up now.
                        r_valid <= 1'b1;
                        r_data  <= r_c;
                        r_fail  <= 1'b1;
                        r_oiter <= r_iter;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
`endif
                    end else if (r_iter == MAX_IT) begin
                        r_valid <= 1'b1;
                        r_data  <= r_c;
                        r_fail  <= 1'b1;
                        r_oiter <= r_iter;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_c     <= r_c ^ w_q;
                        r_iter  <= r_iter + 4'd1;
                        r_state <= ST_SYND;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_ready  = r_ready;
    assign bus.o_valid  = r_valid;
    assign bus.data_out = r_data;
    assign bus.o_fail   = r_fail;
    assign bus.o_iter   = r_oiter;

endmodule

// File: doc/qc_decoder.md
# qc_decoder

Hard-decision bit-flipping decoder for the 27-bit-information / 162-bit-parity QC-LDPC code: the receive-side counterpart of the encoder. It takes a received 189-bit word (27 information bits plus 162 parity bits) and the same 27×162 generator parity rows that the H1 loader provides. It iteratively corrects the information bits and returns them with a success/fail flag. It sits between the channel slicer and the payload sink, sharing the generator-row loader with the encoder.

## Interface
- MAX_ITER, 8: maximum flip iterations per codeword (1..15).
- PAR_ERR_TOL, 2: residual syndrome weight accepted as "parity-only errors" when no information bit qualifies for flipping.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid  in  1  input word present; accepted only on an edge where o_ready is high.
- info_in  in  27  received information bits.
- par_in  in  162  received parity bits.
- h  in  162×[26:0]  generator parity rows; row i is the parity contribution of information bit i. Must be held stable while o_ready is low.
- o_ready  out  1  decoder idle and able to accept a word.
- o_valid  out  1  one-cycle pulse; data_out and o_fail are valid in that cycle.
- data_out  out  27  corrected information bits.
- o_fail  out  1  decoding did not converge.
- o_iter  out  4  flip iterations used (k) for the word being reported.

## Operation
- The FSM has three states: IDLE, SYND and EVAL.
- **IDLE:** o_ready=1. On valid, capture info_in into working register c and par_in into p, clear the iteration counter, and go to SYND. valid with o_ready=0 is ignored (no queueing).
- **SYND:** register the syndrome s = p XOR (XOR over i where c[i]=1 of h[i]). Go to EVAL.
- **EVAL:** for each i:
  - u[i] = popcount(h[i] AND s) (8-bit).
  - w[i] = popcount(h[i]) (8-bit).
  - q[i] = (2·u[i] > w[i]), strict majority.
- EVAL takes the first matching rule, in this order:
  1. s==0: report success.
  2. No q[i] set and popcount(s) ≤ PAR_ERR_TOL: report success. Errors are confined to parity; c is unchanged.
  3. Iteration count == MAX_ITER: report fail.
  4. Otherwise: c ← c XOR q, iteration count +1, go to SYND.
- **Report:** on the leaving edge, set o_valid=1, data_out=c, o_fail and o_iter; next state IDLE. o_ready returns to 1 in the same cycle that o_valid is high.
- All arithmetic is unsigned; both popcounts are 8 bits wide, so there is no overflow for 162 bits.

## Timing
- **Reset values:** o_ready=1, o_valid=0, data_out=0, o_fail=0, o_iter=0, state IDLE.
- **Latency:** o_valid is high exactly 2+2k edges after the accepting edge.
  - k=0 for a clean word (2 edges).
  - Maximum latency is 2+2·MAX_ITER.
- **Throughput:** a new word can be accepted on the edge immediately after the o_valid cycle. valid high during the o_valid cycle itself is also accepted.
- **Reset mid-operation:** rst high on any edge aborts the word. The outputs take their reset values on that edge and no o_valid is emitted for the aborted word.
- **Hold:** data_out, o_fail and o_iter hold their values between o_valid pulses.
- **Simultaneous events:** rst has priority over valid.

## Configuration
- QC_DEC_STALL_DETECT_EN is the single compile-time option.
  - **Defined:** in EVAL, if s≠0, no q[i] is set and popcount(s) > PAR_ERR_TOL, report fail immediately. o_iter is the current count.
  - **Undefined:** that case behaves like rule 4 with q=0; the decoder iterates with no change until MAX_ITER, then reports fail.

## Structure
- **Shared package qc_ldpc_pkg:** the constants K=27, M=162 and N=189, plus the typedefs info_t (logic[26:0]), par_t (logic[161:0]) and grow_t (par_t array [K-1:0]). The encoder and the loader use the same package.
- **Sub-module qc_popcount162:** combinational 162-bit popcount returning 8 bits. It is instantiated for u[i], w[i] and the syndrome weight.

## Test plan
All scenarios use bench rows h[i] with bits 6i..6i+5 set (disjoint, weight 6) and MAX_ITER=8.

- **Clean word:** info_in=27'h0000001, par_in = bits 0..5 set → data_out=27'h1, o_fail=0, o_iter=0, o_valid 2 edges after accept.
- **Single information error:** same word with info bit 3 flipped (info_in=27'h9) → data_out=27'h1, o_fail=0, o_iter=1, latency 4.
- **Single parity error:** info_in=27'h1, parity bit 100 flipped → data_out=27'h1, o_fail=0, o_iter=0, latency 2.
- **Non-convergent word:** info_in=27'h0, parity bits 0, 6 and 12 set → o_fail=1.
  - With QC_DEC_STALL_DETECT_EN: latency 2, o_iter=0.
  - Without it: latency 18, o_iter=8.
- **Handshake:** valid held high for 3 cycles at the first accept → exactly one o_valid pulse. A new word with valid high during that o_valid cycle is accepted.
- **Reset mid-operation:** rst pulsed one cycle after accept → no o_valid, o_ready=1 and data_out=0 on the next cycle. A following clean word decodes correctly.
